display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//   Time-multiplexes one shared decoder4x7 across the microwave's three 7-seg digits
//   (minutes, seconds-tens, seconds-ones).
//   Snapshots the three BCD digits at the start of each frame and drives the decoder's
//   binary_in/enable plus a one-hot digit select.
//   Inserts a blanking gap between digits, suppresses a leading minutes zero, and
//   blinks the whole display on request.
//   Sits between the timer datapath and the single decoder instance / digit drivers.
// PARAMETERS
//   DIV          4   clock cycles each digit is shown per frame (>=1)
//   BLANK_CYCLES 1   all-off cycles after each digit slot (>=0; 0 = no gap state)
//   BLINK_FRAMES 2   frames per blink half-period (>=1)
// PORTS
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  synchronous, active-low reset
//   en         in   1  display enable; 0 = scanning stopped, all dark
//   blink      in   1  1 = blink display (visible/hidden alternating)
//   lz_blank   in   1  1 = hide minutes digit when it is 0
//   digit0     in   4  seconds ones (BCD)
//   digit1     in   4  seconds tens (BCD)
//   digit2     in   4  minutes (BCD)
//   dec_bin    out  4  to decoder4x7 binary_in
//   dec_en     out  1  to decoder4x7 enable
//   digit_sel  out  3  one-hot digit drive, bit i = digit i, active high
//   frame_start out 1  1-cycle pulse in LOAD state
// BEHAVIOUR
//   All outputs registered; dec_bin, dec_en and digit_sel update on the same edge.
//   Reset (rst_n=0 at clk edge): state IDLE; dec_bin=0, dec_en=0, digit_sel=0, frame_start=0.
//     Reset also clears the slot counter, digit index, frame counter and blink phase (visible).
//   Reset mid-frame overrides everything; there is no partial-frame completion.
//   FSM: IDLE -> LOAD -> SHOW -> [GAP] -> SHOW ... -> LOAD.
//   IDLE: outputs dark. If en=1, go to LOAD next cycle.
//   LOAD (1 cycle):
//     - Snapshot digit0..2 and lz_blank; set idx=0; frame_start=1; outputs dark.
//     - Toggle blink phase when the frame counter reaches BLINK_FRAMES-1; the counter wraps to 0.
//   SHOW (DIV cycles): dec_bin=snap[idx], digit_sel=1<<idx, dec_en=1, unless the slot is hidden.
//     Then go to GAP if BLANK_CYCLES>0, else advance.
//   GAP (BLANK_CYCLES cycles): dec_en=0, digit_sel=0; dec_bin holds its last value.
//   Advance: if idx<2, idx+1 -> SHOW; if idx==2, go to LOAD when en=1, else IDLE.
//   Frame length = 1 + 3*(DIV+BLANK_CYCLES) cycles; digit order is 0,1,2.
//   Slot hidden (dec_en=0, digit_sel=0, dec_bin still = snap[idx]) if either:
//     (a) blink=1 and blink phase = hidden, or
//     (b) idx==2, snapped lz_blank=1 and snap digit2==0.
//   blink=0 forces the phase to visible at the next LOAD; the frame counter keeps counting.
//   Snapshot isolation: changes to digit* during a frame are not displayed until the next LOAD.
//   Values >9 pass through unmodified; the decoder defines their glyph.
//   en=0 seen in any non-IDLE state: next state IDLE, outputs dark on that edge.
//     When en returns, the frame restarts at LOAD with idx=0.
//   Slot and gap counters wrap exactly; no state is ever stuck. Unused states decode to IDLE.
// TESTING  (DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2; frame = 16 cycles)
//   1. Reset, en=1, digits 2/5/9 (d0,d1,d2):
//      - frame_start at cycle 1;
//      - sel=001 with bin=2 for cycles 2-5, gap at cycle 6;
//      - sel=010 with bin=5 for cycles 7-10; sel=100 with bin=9 for cycles 12-15;
//      - next frame_start at cycle 17.
//   2. Change d0 from 2 to 7 at cycle 3 -> bin stays 2 for that frame; the next frame shows 7.
//   3. lz_blank=1, d2=0 -> slot 2 has dec_en=0 and sel=000; with d2=1 the slot is shown normally.
//   4. blink=1 for 8 frames -> visible/hidden alternates every 2 frames (V,V,H,H,V,V,H,H).
//      Digit timing is unchanged throughout.
//   5. Drop en at cycle 8 -> the next edge shows all outputs dark and state IDLE.
//      Re-raise en -> LOAD, then digit 0 first.
//   6. Assert rst_n=0 for 1 cycle mid-SHOW -> all outputs 0 on that edge; restart as in test 1.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexes one shared decoder4x7 across three 7-segment digits
//   (seconds ones, seconds tens, minutes). The three BCD digits and the
//   leading-zero option are snapshotted once per frame in LOAD, then each
//   digit is shown for DIV cycles followed by BLANK_CYCLES dark cycles.
//   A leading minutes zero can be suppressed and the display can blink with
//   a half-period of BLINK_FRAMES frames.
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  synchronous active-low reset
//   en          in   1  display enable (0 = scanning stopped, dark)
//   blink       in   1  blink request
//   lz_blank    in   1  hide the minutes digit when it is 0
//   digit0      in   4  seconds ones (BCD)
//   digit1      in   4  seconds tens (BCD)
//   digit2      in   4  minutes (BCD)
//   dec_bin     out  4  decoder binary_in
//   dec_en      out  1  decoder enable
//   digit_sel   out  3  one-hot digit drive, active high
//   frame_start out  1  one-cycle pulse while in LOAD

module display_scan_ctrl #(
   parameter int DIV          = 4,
   parameter int BLANK_CYCLES = 1,
   parameter int BLINK_FRAMES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       blink,
   input  logic       lz_blank,
   input  logic [3:0] digit0,
   input  logic [3:0] digit1,
   input  logic [3:0] digit2,
   output logic [3:0] dec_bin,
   output logic       dec_en,
   output logic [2:0] digit_sel,
   output logic       frame_start
);

   typedef enum logic [1:0] {IDLE, LOAD, SHOW, GAP} state_t;

   localparam int CMAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
   localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

   state_t         state, state_next;
   logic [CW-1:0]  cnt, cnt_next;
   logic [1:0]     idx, idx_next;
   logic           load;
   logic [FW-1:0]  frame_cnt;
   logic           phase;        // running blink phase, 1 = hidden
   logic           frame_phase;  // phase applied to the current frame
   logic [3:0]     snap [3];
   logic           snap_lz;
   logic           hidden;

   // Leaving the last slot of a frame either starts the next frame or parks.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      load       = 1'b0;
      if (state != IDLE && !en) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state_next = LOAD;
                  load       = 1'b1;
               end
            end
            LOAD: begin
               state_next = SHOW;
               idx_next   = 2'd0;
               cnt_next   = '0;
            end
            SHOW, GAP: begin
               if (state == SHOW && cnt != DIV_LAST) begin
                  cnt_next = cnt + 1'b1;
               end else if (state == GAP && cnt != GAP_LAST) begin
                  cnt_next = cnt + 1'b1;
               end else if (state == SHOW && BLANK_CYCLES > 0) begin
                  state_next = GAP;
                  cnt_next   = '0;
               end else if (idx != 2'd2) begin
                  state_next = SHOW;
                  idx_next   = idx + 2'd1;
                  cnt_next   = '0;
               end else begin
                  state_next = LOAD;
                  load       = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // The snapshot is registered before any SHOW cycle, so it is stable here.
   always_comb begin
      hidden = (blink && frame_phase) ||
               (idx_next == 2'd2 && snap_lz && snap[2] == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= 2'd0;
         frame_cnt   <= '0;
         phase       <= 1'b0;
         frame_phase <= 1'b0;
         snap[0]     <= 4'd0;
         snap[1]     <= 4'd0;
         snap[2]     <= 4'd0;
         snap_lz     <= 1'b0;
         dec_bin     <= 4'd0;
         dec_en      <= 1'b0;
         digit_sel   <= 3'b000;
         frame_start <= 1'b0;
      end else begin
         state       <= state_next;
         cnt         <= cnt_next;
         idx         <= idx_next;
         frame_start <= load;
         if (load) begin
            snap[0]     <= digit0;
            snap[1]     <= digit1;
            snap[2]     <= digit2;
            snap_lz     <= lz_blank;
            // A frame uses the phase held at its LOAD; the toggle takes
            // effect from the following frame, giving V,V,H,H from reset.
            frame_phase <= blink & phase;
            frame_cnt   <= (frame_cnt == FRM_LAST) ? '0 : frame_cnt + 1'b1;
            if (!blink)
               phase <= 1'b0;
            else if (frame_cnt == FRM_LAST)
               phase <= ~phase;
         end
         case (state_next)
            SHOW: begin
               dec_bin   <= snap[idx_next];
               dec_en    <= ~hidden;
               digit_sel <= hidden ? 3'b000 : (3'b001 << idx_next);
            end
            IDLE: begin
               dec_bin   <= 4'd0;
               dec_en    <= 1'b0;
               digit_sel <= 3'b000;
            end
            default: begin
               // LOAD and GAP are dark; dec_bin keeps its last value.
               dec_en    <= 1'b0;
               digit_sel <= 3'b000;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       blink = 1'b0;
   logic       lz_blank = 1'b0;
   logic [3:0] digit0 = 4'd0;
   logic [3:0] digit1 = 4'd0;
   logic [3:0] digit2 = 4'd0;
   logic [3:0] dec_bin;
   logic       dec_en;
   logic [2:0] digit_sel;
   logic       frame_start;

   int errors = 0;
   int checks = 0;

   display_scan_ctrl #(.DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .blink(blink), .lz_blank(lz_blank),
      .digit0(digit0), .digit1(digit1), .digit2(digit2),
      .dec_bin(dec_bin), .dec_en(dec_en), .digit_sel(digit_sel),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Runs n cycles of a frame starting with the edge that enters LOAD.
   // Frame position p: 0 = LOAD, then per slot 4 SHOW cycles + 1 GAP cycle.
   // Optionally changes digit0 after the check at position chg_p.
   task automatic run_frame(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                            input logic [3:0] e2, input logic [2:0] vis, input int n,
                            input int chg_p, input logic [3:0] chg_val);
      logic [3:0] ev [3];
      int s, r;
      logic shown;
      ev[0] = e0; ev[1] = e1; ev[2] = e2;
      for (int p = 0; p < n; p++) begin
         tick();
         if (p == 0) begin
            check({tag, " fs"},  {3'b0, frame_start}, 4'd1);
            check({tag, " en"},  {3'b0, dec_en},      4'd0);
            check({tag, " sel"}, {1'b0, digit_sel},   4'd0);
         end else begin
            s = (p - 1) / 5;
            r = (p - 1) % 5;
            shown = (r < 4) && vis[s];
            check({tag, " fs"},  {3'b0, frame_start}, 4'd0);
            check({tag, " en"},  {3'b0, dec_en},      {3'b0, shown});
            check({tag, " sel"}, {1'b0, digit_sel},   shown ? (4'd1 << s) : 4'd0);
            check({tag, " bin"}, dec_bin,             ev[s]);
         end
         if (p == chg_p) digit0 = chg_val;
      end
      $display("frame %s: digits %0h/%0h/%0h vis=%b cycles=%0d errors=%0d", tag, e0, e1, e2, vis, n, errors);
   endtask

   task automatic check_dark(input string tag);
      check({tag, " fs"},  {3'b0, frame_start}, 4'd0);
      check({tag, " en"},  {3'b0, dec_en},      4'd0);
      check({tag, " sel"}, {1'b0, digit_sel},   4'd0);
   endtask

   initial begin
      // Reset with en=1 and digits 2/5/9
      en = 1'b1; digit0 = 4'd2; digit1 = 4'd5; digit2 = 4'd9;
      tick();
      tick();
      check_dark("reset");
      check("reset bin", dec_bin, 4'd0);
      $display("reset: dec_bin=%0h dec_en=%0b sel=%b fs=%0b", dec_bin, dec_en, digit_sel, frame_start);
      rst_n = 1'b1;

      // Frame 1: cycles 1..16, digit0 changes to 7 during cycle 3 (p=2)
      run_frame("f1", 4'd2, 4'd5, 4'd9, 3'b111, 16, 2, 4'd7);
      // Frame 2 begins at cycle 17 and shows the new digit0
      run_frame("f2", 4'd7, 4'd5, 4'd9, 3'b111, 16, -1, 4'd0);

      // Leading-zero suppression of the minutes digit
      lz_blank = 1'b1; digit2 = 4'd0;
      run_frame("lz0", 4'd7, 4'd5, 4'd0, 3'b011, 16, -1, 4'd0);
      digit2 = 4'd1;
      run_frame("lz1", 4'd7, 4'd5, 4'd1, 3'b111, 16, -1, 4'd0);
      lz_blank = 1'b0;

      // Blink over 8 frames: V,V,H,H,V,V,H,H
      blink = 1'b1;
      run_frame("bl1", 4'd7, 4'd5, 4'd1, 3'b111, 16, -1, 4'd0);
      run_frame("bl2", 4'd7, 4'd5, 4'd1, 3'b111, 16, -1, 4'd0);
      run_frame("bl3", 4'd7, 4'd5, 4'd1, 3'b000, 16, -1, 4'd0);
      run_frame("bl4", 4'd7, 4'd5, 4'd1, 3'b000, 16, -1, 4'd0);
      run_frame("bl5", 4'd7, 4'd5, 4'd1, 3'b111, 16, -1, 4'd0);
      run_frame("bl6", 4'd7, 4'd5, 4'd1, 3'b111, 16, -1, 4'd0);
      run_frame("bl7", 4'd7, 4'd5, 4'd1, 3'b000, 16, -1, 4'd0);
      run_frame("bl8", 4'd7, 4'd5, 4'd1, 3'b000, 16, -1, 4'd0);
      blink = 1'b0;
      run_frame("noblink", 4'd7, 4'd5, 4'd1, 3'b111, 16, -1, 4'd0);

      // Drop en at cycle 8 (digit 1 showing) -> next edge dark
      run_frame("en_pre", 4'd7, 4'd5, 4'd1, 3'b111, 8, -1, 4'd0);
      en = 1'b0;
      tick();
      check_dark("en_drop");
      tick();
      tick();
      check_dark("en_idle");
      $display("en drop: dec_en=%0b sel=%b fs=%0b", dec_en, digit_sel, frame_start);
      en = 1'b1;
      run_frame("en_back", 4'd7, 4'd5, 4'd1, 3'b111, 16, -1, 4'd0);

      // Reset for one cycle mid-SHOW
      run_frame("rst_pre", 4'd7, 4'd5, 4'd1, 3'b111, 4, -1, 4'd0);
      rst_n = 1'b0;
      tick();
      check_dark("rst_mid");
      check("rst_mid bin", dec_bin, 4'd0);
      $display("mid reset: dec_bin=%0h dec_en=%0b sel=%b fs=%0b", dec_bin, dec_en, digit_sel, frame_start);
      rst_n = 1'b1;
      run_frame("rst_post", 4'd7, 4'd5, 4'd1, 3'b111, 16, -1, 4'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
